// File: rtl/ofifo_collector.sv
// ofifo_collector
//   Output-side buffer bank for the MAC array. Each column lane is an
//   independent circular buffer that takes the staggered partial-sum writes
//   from the array's bottom edge. A read pops one aligned, full-width word,
//   and a word is available only once every lane holds at least one entry.
//
//   Handshake: o_valid means an aligned word is available. A pop happens on
//   a rising edge where rd && o_valid, and the popped word shows up on out
//   one cycle later. o_ready (== !o_full) tells the producer that every lane
//   can accept a write. A write to a full lane is dropped and sets the
//   sticky o_overflow flag.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   in         : column data, lane i at in[psum_bw*(i+1)-1 : psum_bw*i]
//   wr         : per-lane write strobe
//   rd         : pop request for one aligned word
//   out        : registered aligned output word (same lane slicing as in)
//   o_valid    : every lane is non-empty
//   o_full     : at least one lane is full
//   o_ready    : !o_full
//   o_overflow : sticky, a write was dropped on a full lane
module ofifo_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*psum_bw-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [col*psum_bw-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = 1;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [aw:0]          wr_ptr_q [col];
  logic [aw:0]          wr_ptr_d [col];
  logic [aw:0]          rd_ptr_q [col];
  logic [aw:0]          rd_ptr_d [col];
  logic [psum_bw-1:0]   mem_q    [col][depth];

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         wr_accept;
  logic [col-1:0]         wr_drop;
  logic [col*psum_bw-1:0] head_word;
  logic [col*psum_bw-1:0] out_q;
  logic [col*psum_bw-1:0] out_d;
  logic                   overflow_q;
  logic                   overflow_d;
  logic                   pop;

  // Per-lane status and head-of-queue data, taken from the current pointers.
  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    head_word  = '0;
    for (int i = 0; i < col; i++) begin
      lane_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      lane_full[i]  = (wr_ptr_q[i][aw] != rd_ptr_q[i][aw]) &&
                      (wr_ptr_q[i][aw-1:0] == rd_ptr_q[i][aw-1:0]);
      head_word[i*psum_bw +: psum_bw] = mem_q[i][rd_ptr_q[i][aw-1:0]];
    end
  end

  assign o_valid    = &(~lane_empty);
  assign o_full     = |lane_full;
  assign o_ready    = ~o_full;
  assign o_overflow = overflow_q;
  assign out        = out_q;

  // Fullness is judged at the start of the cycle, so a pop in the same cycle
  // never opens a slot for a write to a lane that was already full.
  assign wr_accept = wr & ~lane_full;
  assign wr_drop   = wr & lane_full;
  assign pop       = rd & o_valid;

  always_comb begin
    for (int i = 0; i < col; i++) begin
      wr_ptr_d[i] = wr_accept[i] ? (wr_ptr_q[i] + ptr_one) : wr_ptr_q[i];
      rd_ptr_d[i] = pop          ? (rd_ptr_q[i] + ptr_one) : rd_ptr_q[i];
    end
    out_d      = pop ? head_word : out_q;
    overflow_d = overflow_q | (|wr_drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_accept[i]) begin
        mem_q[i][wr_ptr_q[i][aw-1:0]] <= in[i*psum_bw +: psum_bw];
      end
    end
  end

endmodule

// File: tb/tb_ofifo_collector.sv
// tb_ofifo_collector
//   Directed and randomized stimulus for ofifo_collector. The reference model
//   keeps one queue per lane and follows the buffer rules directly: a push
//   lands at the back of a lane queue unless that lane already holds depth
//   entries, and a pop takes the front of every queue once all queues are
//   non-empty.
module tb_ofifo_collector;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int W     = COL * BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid, o_full, o_ready, o_overflow;

  ofifo_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  // ---------------- scoreboard / model ----------------
  logic [BW-1:0] exp_q [COL][$];
  logic [W-1:0]  out_m;
  logic          ovf_m;
  int            checks   = 0;
  int            failures = 0;
  string         phase    = "init";

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic model_valid();
    for (int i = 0; i < COL; i++) if (exp_q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < COL; i++) if (exp_q[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    chk("out",        out,              out_m);
    chk("o_valid",    W'(o_valid),      W'(model_valid()));
    chk("o_full",     W'(o_full),       W'(model_full()));
    chk("o_ready",    W'(o_ready),      W'(!model_full()));
    chk("o_overflow", W'(o_overflow),   W'(ovf_m));
  endtask

  task automatic model_clear();
    for (int i = 0; i < COL; i++) exp_q[i].delete();
    out_m = '0;
    ovf_m = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, update the model, check just after the edge.
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    logic [COL-1:0] full_pre;
    logic           do_pop;
    wr = w; in = d; rd = r;
    for (int i = 0; i < COL; i++) full_pre[i] = (exp_q[i].size() == DEPTH);
    do_pop = r && model_valid();
    if (do_pop) begin
      for (int i = 0; i < COL; i++) out_m[i*BW +: BW] = exp_q[i].pop_front();
    end
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (full_pre[i]) ovf_m = 1'b1;
        else exp_q[i].push_back(d[i*BW +: BW]);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    wr = '0; rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_outputs();
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'($urandom_range(0, 65535));
    return v;
  endfunction

  function automatic logic [W-1:0] fill_word(input logic [BW-1:0] val);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = val;
    return v;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] d;
    logic [BW-1:0] cnt;

    // Reset, then idle.
    phase = "reset_idle";
    do_reset();
    repeat (5) step('0, '0, 1'b0);

    // Asynchronous reset landing between edges with live data.
    phase = "async_reset";
    step('1, rand_word(), 1'b0);
    step('0, '0, 1'b1);
    step('1, rand_word(), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();

    // Staggered fill: lane i written at cycle i.
    phase = "staggered";
    do_reset();
    for (int i = 0; i < COL; i++) begin
      d = '0;
      for (int j = 0; j < COL; j++) d[j*BW +: BW] = BW'(16'h0100 + j);
      step(COL'(1) << i, d, 1'b0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    chk("aligned_word", out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                              16'h0103, 16'h0102, 16'h0101, 16'h0100});

    // Read request while the slowest lane is still empty.
    phase = "read_not_valid";
    do_reset();
    step(8'h7F, rand_word(), 1'b0);
    step('0, '0, 1'b1);
    step(8'h80, rand_word(), 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);

    // Fill every lane, drop an extra write on lane 3, then drain.
    phase = "full_overflow";
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, rand_word(), 1'b0);
    d = '0;
    d[3*BW +: BW] = 16'hDEAD;
    step(8'h08, d, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step('0, '0, 1'b1);
      chk("no_dead", W'(out[3*BW +: BW] == 16'hDEAD), W'(1'b0));
    end
    step('0, '0, 1'b1);

    // Hold 32 entries, then stream push+pop across the pointer wrap.
    phase = "simultaneous";
    do_reset();
    cnt = 16'h0;
    for (int k = 0; k < 32; k++) begin
      step('1, fill_word(cnt), 1'b0);
      cnt++;
    end
    for (int k = 0; k < 100; k++) begin
      step('1, fill_word(cnt), 1'b1);
      chk("fifo_order", out, fill_word(BW'(k)));
      cnt++;
    end
    for (int k = 0; k < 32; k++) step('0, '0, 1'b1);
    chk("drained_valid", W'(o_valid), W'(1'b0));

    // Lane 0 full, other lanes non-empty, write lane 0 and pop together.
    phase = "full_and_read";
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(8'h01, rand_word(), 1'b0);
    step(8'hFE, rand_word(), 1'b0);
    step(8'h01, rand_word(), 1'b1);
    chk("lane0_count", W'(exp_q[0].size()), W'(DEPTH - 1));
    step(8'h01, rand_word(), 1'b0);

    // Random traffic.
    phase = "random";
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(COL'($urandom_range(0, 255)), rand_word(), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ofifo_collector.md
Name: ofifo_collector

Overview:
- Output-side buffer bank for the MAC array. It is the mirror of the input L0 stage, which takes parallel writes and reads rows out staggered.
- This block accepts staggered, per-column partial-sum writes from the array's bottom edge and releases one aligned, full-width word per read once every column holds data.
- It sits between the MAC array outputs and the SFU/PSUM SRAM write path.

Parameters:
- col, 8, number of array columns, i.e. independent lanes.
- psum_bw, 16, bit width of one partial sum per column.
- depth, 64, entries per column lane; must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  col*psum_bw  column data; lane i occupies in[psum_bw*(i+1)-1 : psum_bw*i].
- wr  input  col  per-lane write strobe; wr[i] qualifies lane i only.
- rd  input  1  request to pop one aligned word from all lanes.
- out  output  col*psum_bw  registered aligned output word; lane i uses the same slice as in.
- o_valid  output  1  every lane non-empty, so an aligned word is available.
- o_full  output  1  at least one lane is full.
- o_ready  output  1  equals !o_full.
- o_overflow  output  1  sticky flag: a write was dropped on a full lane.

Behaviour:
- Storage: col independent circular buffers, each of depth entries × psum_bw bits.
- Pointers: per-lane wr_ptr and rd_ptr, each log2(depth)+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low bits are equal.
- Reset (asynchronous, immediate): all pointers = 0; out = 0; o_overflow = 0; o_valid = 0; o_full = 0; o_ready = 1. Memory contents are don't-care. A reset asserted mid-stream discards all buffered data.
- Status outputs are combinational from pointer state:
  - o_valid = AND over all lanes of !empty.
  - o_full = OR over all lanes of full.
- Write, evaluated per lane i each edge:
  - If wr[i] and lane i is not full at the start of the cycle: store in-slice at wr_ptr[i] and increment wr_ptr[i] with wrap.
  - If wr[i] and lane i is full: drop the write and set o_overflow = 1. o_overflow holds until reset.
  - A pop in the same cycle does not make room for a write to a lane that was full at the start of the cycle.
- Read:
  - If rd and o_valid at the edge: out <= head entry of every lane, and every rd_ptr increments with wrap.
  - Latency: data appears on out one cycle after the accepted rd edge.
  - If rd and !o_valid: no pop, out holds its previous value, no error flag.
- Simultaneous write and read on a non-full lane: both occur; the occupancy of that lane is unchanged.
- Lanes fill at different times, which is expected given staggered column timing. o_valid rises only when the slowest lane receives its first entry.
- Lanes stay aligned: the k-th accepted write on each lane forms the k-th output word, regardless of per-lane write timing.
- Wrap-around: after depth pushes and pops, pointer low bits return to 0 and the MSB toggles. Data order must be preserved across the wrap.
- Occupancy never exceeds depth. out changes only on an accepted read or on reset.

Test Plan:
- Reset, then idle 5 cycles.
  - Required: out = 0, o_valid = 0, o_full = 0, o_ready = 1, o_overflow = 0.
  - Repeat with reset asserted between clock edges; outputs must clear immediately.
- Staggered fill: wr[i] pulses at cycle i (i = 0..7) with lane i data = 16'h0100+i.
  - Required: o_valid = 0 through cycle 7 and = 1 from cycle 8.
  - rd at cycle 9 -> out = {16'h0107, …, 16'h0100} at cycle 10, then o_valid = 0.
- Read when not valid: lanes 0..6 hold one entry, lane 7 is empty; pulse rd.
  - Required: no pointer change and out unchanged.
  - After one wr[7], rd -> aligned word appears.
- Full/overflow: 64 writes to all lanes.
  - Required: o_full = 1, o_ready = 0.
  - A 65th write of 16'hDEAD to lane 3 is dropped and o_overflow = 1.
  - The next 64 reads return the original sequence; DEAD never appears. o_overflow stays 1.
- Simultaneous traffic: hold 32 entries per lane, then assert wr = 8'hFF and rd together for 100 cycles with incrementing data.
  - Required: occupancy stays at 32 and output words are in strict FIFO order across the pointer wrap.
- Full plus simultaneous read: lane 0 full, others non-empty; wr[0] and rd asserted in the same cycle.
  - Required: lane 0's write is dropped, o_overflow = 1, one pop occurs, and lane 0 ends with 63 entries.
